// File: rtl/deser_sync_ctrl.sv
// Link-sync controller behind the 8-bit deserializer: acquires word lock on
// consecutive COM symbols, strips K symbols, and forwards data bytes while locked.
module deser_sync_ctrl #(
  parameter int unsigned BITS       = 8,
  parameter logic [BITS-1:0] COM_VAL = BITS'(8'hBC),
  parameter logic [BITS-1:0] IDL_VAL = BITS'(8'h7C),
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 3
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  input  logic            in_dk,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic            active,
  output logic            lock_lost,
  output logic [7:0]      err_total
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LOCK_CNT_W = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] ERR_LIM_W  = CW'(ERR_LIMIT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] com_cnt;
  logic [CW-1:0] err_cnt;

  logic          is_com;
  logic          is_idle;
  logic [CW-1:0] com_inc;
  logic [CW-1:0] err_inc;

  // Symbol classification and counter increments for the current input byte.
  always_comb begin
    is_com  = in_dk && (in_data == COM_VAL);
    is_idle = in_dk && (in_data == IDL_VAL);
    com_inc = com_cnt + CW'(1);
    err_inc = err_cnt + CW'(1);
  end

  // Lock FSM with registered outputs; everything advances only on accepted bytes.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEARCH;
      com_cnt   <= '0;
      err_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      active    <= 1'b0;
      lock_lost <= 1'b0;
      err_total <= 8'd0;
    end else begin
      out_valid <= 1'b0;
      lock_lost <= 1'b0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            if (is_com) begin
              state   <= LOCKING;
              com_cnt <= CW'(1);
            end
          end
          LOCKING: begin
            if (is_com) begin
              if (com_inc == LOCK_CNT_W) begin
                state   <= ACTIVE;
                active  <= 1'b1;
                com_cnt <= '0;
                err_cnt <= '0;
              end else begin
                com_cnt <= com_inc;
              end
            end else begin
              state   <= SEARCH;
              com_cnt <= '0;
            end
          end
          ACTIVE: begin
            if (!in_dk) begin
              out_valid <= 1'b1;
              out_data  <= in_data;
            end else if (is_com) begin
              err_cnt <= '0;
            end else if (!is_idle) begin
              if (err_total != 8'hFF) begin
                err_total <= err_total + 8'd1;
              end
              if (err_inc == ERR_LIM_W) begin
                state     <= SEARCH;
                active    <= 1'b0;
                lock_lost <= 1'b1;
                err_cnt   <= '0;
              end else begin
                err_cnt <= err_inc;
              end
            end
          end
          default: begin
            state   <= SEARCH;
            com_cnt <= '0;
            err_cnt <= '0;
            active  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
